// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants, operation codes and FSM states for the multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  // Absolute value for signed operations; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             is_signed);
    return (is_signed && value[WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, MTHI/MTLO and result signals between decode and the MDU.
interface mult_div_unit_if;
  import mdu_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration, either shift-add (multiply) or
// shift-subtract-restore (divide), on a 64-bit {upper, lower} accumulator.
module mdu_step
  import mdu_pkg::*;
(
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;

  // Multiply adds the multiplicand when the low bit is set and shifts right;
  // divide shifts left and keeps the trial subtraction only when it does not go negative.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    diff      = {1'b0, rem_shift} - {2'b00, operand};
    if (!mode) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (diff[WIDTH+1:WIDTH] == 2'b00) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide unit with HI/LO result registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_unit_if.slave bus
);

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               op_signed;
  logic               is_div;
  logic               neg_result;
  logic               neg_rem;
  logic               div_zero;
  logic               last_iter;

  // Magnitudes of the request currently on the bus, captured when start is accepted.
  always_comb begin
    op_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    a_mag     = magnitude(bus.a, op_signed);
    b_mag     = magnitude(bus.b, op_signed);
  end

  mdu_step u_step (
    .mode     (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // Sign-correct the final iteration so HI/LO load the finished result in one step.
  always_comb begin
    product = neg_result ? -acc_next : acc_next;
    res_hi  = product[2*WIDTH-1:WIDTH];
    res_lo  = product[WIDTH-1:0];
    if (is_div) begin
      res_lo = neg_result ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
      res_hi = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end
  end

  assign last_iter = (cnt == CNT_W'(ITERATIONS - 1));
  assign bus.busy  = (state == ST_RUN);

  // Sequencer: accept a request, run 32 iterations, publish HI/LO, then pulse done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      acc             <= '0;
      operand         <= '0;
      is_div          <= 1'b0;
      neg_result      <= 1'b0;
      neg_rem         <= 1'b0;
      div_zero        <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done        <= (state == ST_FIN);
      bus.div_by_zero <= (state == ST_FIN) && div_zero;
      case (state)
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state <= ST_FIN;
            if (!div_zero) begin
              bus.hi <= res_hi;
              bus.lo <= res_lo;
            end
          end
        end
        default: begin
          if (bus.start) begin
            state      <= ST_RUN;
            cnt        <= '0;
            is_div     <= bus.op[1];
            neg_result <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem    <= op_signed && bus.a[WIDTH-1];
            div_zero   <= bus.op[1] && (bus.b == '0);
            if (bus.op[1]) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              operand <= b_mag;
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_mag};
              operand <= a_mag;
            end
          end else begin
            state <= ST_IDLE;
            if (bus.hi_we) bus.hi <= bus.wdata;
            if (bus.lo_we) bus.lo <= bus.wdata;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 a  input  32  multiplicand / dividend (rs value from register read).
REQ-007 b  input  32  multiplier / divisor (rt value from register read).
REQ-008 hi_we  input  1  MTHI write strobe.
REQ-009 lo_we  input  1  MTLO write strobe.
REQ-010 wdata  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  operation in progress; decode stalls MFHI/MFLO/new MDU ops while high.
REQ-012 done  output  1  one-cycle pulse: hi/lo now hold the result.
REQ-013 div_by_zero  output  1  one-cycle pulse with done when a DIV/DIVU had b=0.
REQ-014 hi  output  32  HI register (product[63:32] / remainder).
REQ-015 lo  output  32  LO register (product[31:0] / quotient).

Function
REQ-016 FSM states: IDLE, RUN, FIN; IDLE->RUN on start=1; RUN->FIN after 32 iteration cycles; FIN->IDLE unconditionally, or FIN->RUN if start=1 in FIN.
REQ-017 On the start edge, a, b, op are captured; later changes to a/b/op do not affect the running operation.
REQ-018 busy = 1 in RUN only; busy = 0 in IDLE and FIN.
REQ-019 Latency: start sampled at edge N -> done=1 and hi/lo valid during cycle after edge N+33; exactly 32 RUN cycles.
REQ-020 Multiply: radix-2 shift-add on operand magnitudes; 64-bit product; signed ops negate product when a[31]^b[31].
REQ-021 Divide: restoring, one quotient bit per RUN cycle on magnitudes; quotient truncates toward zero; remainder takes the sign of a.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, div_by_zero=0.
REQ-023 Divide with b=0: full 33-cycle latency, hi/lo unchanged, done=1 and div_by_zero=1 for one cycle.
REQ-024 hi/lo are written only on the RUN->FIN edge (result) or by hi_we/lo_we; they never show intermediate values.
REQ-025 hi_we/lo_we honoured only when busy=0 and start=0; ignored otherwise (start wins on same cycle).
REQ-026 hi_we and lo_we together both write wdata.
REQ-027 start while busy=1 is ignored; no queuing.

Reset
REQ-028 reset=1 at any edge (including mid-RUN) forces IDLE, aborts the operation, and sets hi=0, lo=0, busy=0, done=0, div_by_zero=0.
REQ-029 reset has priority over start, hi_we, lo_we.

Structure
REQ-030 Shared package mdu_pkg holds: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), FSM state encoding, WIDTH, iteration count 32.
REQ-031 One sub-module mdu_step: combinational single iteration (add-shift or subtract-restore), selected by a mode bit; instantiated once.
REQ-032 Iteration counter is 5 bits wide, wrapping from 31 to 0 on the RUN->FIN transition.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done one cycle.
REQ-034 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU a=100 b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> hi=0x11, lo=0x22, done=div_by_zero=1 one cycle.
REQ-036 start DIVU a=100 b=7, change a/b and pulse start again at cycle 10 -> second start ignored, lo=14, hi=2.
REQ-037 reset asserted at RUN cycle 16 of MULT -> next cycle busy=0, hi=lo=0, no done pulse ever issued.
REQ-038 Back-to-back: start in FIN cycle -> second result after a further 33 cycles, busy low only in the FIN cycle.
